// File: rtl/ama_riscv_pkg.sv
// Shared types for the data-memory arbiter: requester IDs, request payload, helpers.
package ama_riscv_pkg;

    localparam int ARCH_WIDTH = 32;
    localparam int ARB_N_SRC  = 2;

    typedef enum logic {
        ARB_SRC_CORE = 1'b0,
        ARB_SRC_AUX  = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic [ARCH_WIDTH-1:0] addr;
        logic [ARCH_WIDTH-1:0] wdata;
        logic                  rtype;
        logic [1:0]            dtype;
    } dmem_arb_req_t;

    function automatic arb_src_t arb_other_src(input arb_src_t src);
        return (src == ARB_SRC_CORE) ? ARB_SRC_AUX : ARB_SRC_CORE;
    endfunction

endpackage

// File: rtl/ama_riscv_dmem_arb_fifo.sv
// In-order tracking FIFO of requester IDs for accepted-but-unanswered dcache requests.
// Pointers carry one extra MSB so full and empty are distinguishable without a flag.
module ama_riscv_dmem_arb_fifo
    import ama_riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  arb_src_t         push_src,
    input  logic             pop,
    output arb_src_t         head,
    output logic [CNT_W-1:0] count
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << AW;

    arb_src_t       mem_r [SLOTS];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic [AW:0]    fill_s;

    // Storage and pointer update; the arbiter never pushes when full nor pops when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            for (int i = 0; i < SLOTS; i++) begin
                mem_r[i] <= ARB_SRC_CORE;
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_src;
                wr_ptr_r                <= wr_ptr_r + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            end
        end
    end

    assign fill_s = wr_ptr_r - rd_ptr_r;
    assign count  = fill_s[CNT_W-1:0];
    assign head   = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/ama_riscv_dmem_arbiter.sv
// Shares the dcache request port between the core LSU (src 0) and an auxiliary requester.
// Build option DMEM_ARB_RR_EN selects round-robin; otherwise the core has fixed priority.
module ama_riscv_dmem_arbiter
    import ama_riscv_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ADDR_W    = ARCH_WIDTH,
    parameter int DATA_W    = ARCH_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ARB_N_SRC-1:0]                req_valid,
    output logic [ARB_N_SRC-1:0]                req_ready,
    input  logic [ARB_N_SRC-1:0][ADDR_W-1:0]    req_addr,
    input  logic [ARB_N_SRC-1:0][DATA_W-1:0]    req_wdata,
    input  logic [ARB_N_SRC-1:0]                req_rtype,
    input  logic [ARB_N_SRC-1:0][1:0]           req_dtype,
    output logic                                dc_req_valid,
    input  logic                                dc_req_ready,
    output logic [ADDR_W-1:0]                   dc_req_addr,
    output logic [DATA_W-1:0]                   dc_req_wdata,
    output logic                                dc_req_rtype,
    output logic [1:0]                          dc_req_dtype,
    input  logic                                dc_rsp_valid,
    input  logic [DATA_W-1:0]                   dc_rsp_data,
    output logic [ARB_N_SRC-1:0]                rsp_valid,
    output logic [DATA_W-1:0]                   rsp_data,
    output logic [$clog2(MAX_OUTST+1)-1:0]      outst_cnt,
    output logic                                err_unexp_rsp
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    arb_src_t               grant_s;
    arb_src_t               lock_src_r;
    arb_src_t               fifo_head_s;
    logic                   lock_r;
    logic [ARB_N_SRC-1:0]   elig_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   hs_s;
    logic                   pop_s;
    logic                   err_r;

`ifdef DMEM_ARB_RR_EN
    arb_src_t               rr_ptr_r;

    // Priority pointer: after a handshake the other source wins the next conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= ARB_SRC_CORE;
        end else if (hs_s) begin
            rr_ptr_r <= arb_other_src(grant_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    assign full_s  = (outst_cnt == CNT_W'(MAX_OUTST));
    assign empty_s = (outst_cnt == {CNT_W{1'b0}});

    // Grant selection; a stalled request keeps its source until the handshake
    always_comb begin
        grant_s = ARB_SRC_CORE;
        elig_s  = req_valid;
        if (lock_r) begin
            grant_s = lock_src_r;
            elig_s  = req_valid & ((lock_src_r == ARB_SRC_AUX) ? 2'b10 : 2'b01);
        end else begin
`ifdef DMEM_ARB_RR_EN
            if (req_valid == 2'b11) begin
                grant_s = rr_ptr_r;
            end else if (req_valid[1]) begin
                grant_s = ARB_SRC_AUX;
            end else begin
                grant_s = ARB_SRC_CORE;
            end
`else
            if (req_valid[0]) begin
                grant_s = ARB_SRC_CORE;
            end else if (req_valid[1]) begin
                grant_s = ARB_SRC_AUX;
            end else begin
                grant_s = ARB_SRC_CORE;
            end
`endif
        end
    end

    assign dc_req_valid = (|elig_s) & ~full_s;
    assign hs_s         = dc_req_valid & dc_req_ready;
    assign pop_s        = dc_rsp_valid & ~empty_s;

    // Payload mux and per-source ready
    always_comb begin
        dc_req_addr  = req_addr[grant_s];
        dc_req_wdata = req_wdata[grant_s];
        dc_req_rtype = req_rtype[grant_s];
        dc_req_dtype = req_dtype[grant_s];
        req_ready    = 2'b00;
        if (hs_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Response routing to the oldest outstanding requester
    always_comb begin
        rsp_valid = 2'b00;
        rsp_data  = {DATA_W{1'b0}};
        if (pop_s) begin
            rsp_valid[fifo_head_s] = 1'b1;
            rsp_data               = dc_rsp_data;
        end else begin
            rsp_valid = 2'b00;
            rsp_data  = {DATA_W{1'b0}};
        end
    end

    // Lock holds the granted source while the dcache stalls a valid request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r     <= 1'b0;
            lock_src_r <= ARB_SRC_CORE;
        end else if (dc_req_valid && !dc_req_ready) begin
            lock_r     <= 1'b1;
            lock_src_r <= grant_s;
        end else begin
            lock_r     <= 1'b0;
            lock_src_r <= lock_src_r;
        end
    end

    // Sticky flag for a response with nothing in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (dc_rsp_valid && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_unexp_rsp = err_r;

    ama_riscv_dmem_arb_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (hs_s),
        .push_src (grant_s),
        .pop      (pop_s),
        .head     (fifo_head_s),
        .count    (outst_cnt)
    );

endmodule

// File: tb/tb_ama_riscv_dmem_arbiter.sv
// Randomized scoreboard bench for ama_riscv_dmem_arbiter (MAX_OUTST = 2).
module tb_ama_riscv_dmem_arbiter;

    localparam int MAX_OUTST = 2;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][31:0]     req_addr;
    logic [1:0][31:0]     req_wdata;
    logic [1:0]           req_rtype;
    logic [1:0][1:0]      req_dtype;
    logic                 dc_req_valid;
    logic                 dc_req_ready;
    logic [31:0]          dc_req_addr;
    logic [31:0]          dc_req_wdata;
    logic                 dc_req_rtype;
    logic [1:0]           dc_req_dtype;
    logic                 dc_rsp_valid;
    logic [31:0]          dc_rsp_data;
    logic [1:0]           rsp_valid;
    logic [31:0]          rsp_data;
    logic [CNT_W-1:0]     outst_cnt;
    logic                 err_unexp_rsp;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // reference model state
    int q_m[$];
    int exp_q[$];
    int held_m = -1;
    int prio_m = 0;
    bit err_m  = 1'b0;

    ama_riscv_dmem_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rtype     (req_rtype),
        .req_dtype     (req_dtype),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_addr   (dc_req_addr),
        .dc_req_wdata  (dc_req_wdata),
        .dc_req_rtype  (dc_req_rtype),
        .dc_req_dtype  (dc_req_dtype),
        .dc_rsp_valid  (dc_rsp_valid),
        .dc_rsp_data   (dc_rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .outst_cnt     (outst_cnt),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        req_valid    = 2'b00;
        dc_req_ready = 1'b0;
        dc_rsp_valid = 1'b0;
        dc_rsp_data  = 32'h0;
        req_addr     = '0;
        req_wdata    = '0;
        req_rtype    = 2'b00;
        req_dtype    = '0;
    endtask

    task automatic clear_model();
        q_m.delete();
        exp_q.delete();
        held_m = -1;
        prio_m = 0;
        err_m  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dc_req_valid"}, {63'd0, dc_req_valid}, 64'd0);
        chk({tag, "_req_ready"}, {62'd0, req_ready}, 64'd0);
        chk({tag, "_rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_data"}, {32'd0, rsp_data}, 64'd0);
        chk({tag, "_dc_req_addr"}, {32'd0, dc_req_addr}, 64'd0);
        chk({tag, "_outst_cnt"}, 64'(outst_cnt), 64'd0);
        chk({tag, "_err"}, {63'd0, err_unexp_rsp}, 64'd0);
    endtask

    // One bus cycle: drive, compare combinational outputs with the model, advance the model.
    task automatic cyc(input logic [1:0] v, input logic rdy, input logic rsp);
        int  cand;
        bit  full;
        bit  dcv;
        bit  hs;
        logic [1:0] exp_rdy;
        @(posedge clk);
        #1;
        req_valid    = v;
        dc_req_ready = rdy;
        dc_rsp_valid = rsp;
        dc_rsp_data  = $urandom;
        for (int s = 0; s < 2; s++) begin
            if (s != held_m) begin
                req_addr[s]  = $urandom;
                req_wdata[s] = $urandom;
                req_rtype[s] = 1'($urandom);
                req_dtype[s] = 2'($urandom_range(2, 0));
            end
        end
        #3;
        full = (q_m.size() == MAX_OUTST);
        cand = -1;
        if (held_m >= 0) begin
            cand = v[held_m] ? held_m : -1;
        end else if (v == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            cand = prio_m;
`else
            cand = 0;
`endif
        end else if (v[0]) begin
            cand = 0;
        end else if (v[1]) begin
            cand = 1;
        end
        dcv     = (cand >= 0) && !full;
        hs      = dcv && rdy;
        exp_rdy = hs ? (2'b01 << cand) : 2'b00;
        chk("dc_req_valid", {63'd0, dc_req_valid}, {63'd0, dcv});
        chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
        chk("outst_cnt", 64'(outst_cnt), 64'(q_m.size()));
        chk("err_unexp_rsp", {63'd0, err_unexp_rsp}, {63'd0, err_m});
        if (dcv) begin
            chk("dc_req_addr", {32'd0, dc_req_addr}, {32'd0, req_addr[cand]});
            chk("dc_req_wdata", {32'd0, dc_req_wdata}, {32'd0, req_wdata[cand]});
            chk("dc_req_rtype", {63'd0, dc_req_rtype}, {63'd0, req_rtype[cand]});
            chk("dc_req_dtype", {62'd0, dc_req_dtype}, {62'd0, req_dtype[cand]});
        end
        if (rsp) begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            else err_m = 1'b1;
        end
        if (hs) begin
            q_m.push_back(cand);
            exp_q.push_back(cand);
            prio_m = 1 - cand;
        end
        held_m = (dcv && !rdy) ? cand : -1;
    endtask

    // Scoreboard monitor: every dcache response must route to the oldest expected source
    always @(negedge clk) begin
        int e;
        if (rst_n === 1'b1) begin
            if (dc_rsp_valid === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_route", {62'd0, rsp_valid}, {62'd0, 2'b01 << e});
                    chk("rsp_data", {32'd0, rsp_data}, {32'd0, dc_rsp_data});
                end else begin
                    chk("rsp_none", {62'd0, rsp_valid}, 64'd0);
                end
            end else if (rsp_valid !== 2'b00) begin
                chk("rsp_spurious", {62'd0, rsp_valid}, 64'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        clear_model();
        repeat (3) @(posedge clk);
        #4;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // both requesting, dcache always ready, responses keep the FIFO from filling
        cyc(2'b11, 1'b1, 1'b0);
        repeat (4) cyc(2'b11, 1'b1, 1'b1);
        repeat (2) cyc(2'b00, 1'b0, 1'b1);

        // core stalled three cycles, aux joins while core is held
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b10, 1'b1, 1'b0);
        repeat (2) cyc(2'b00, 1'b0, 1'b1);

        // fill to MAX_OUTST, response while full still blocks the grant
        cyc(2'b01, 1'b1, 1'b0);
        cyc(2'b01, 1'b1, 1'b0);
        cyc(2'b01, 1'b1, 1'b0);
        cyc(2'b01, 1'b1, 1'b1);
        cyc(2'b01, 1'b1, 1'b0);
        repeat (2) cyc(2'b00, 1'b0, 1'b1);

        // push and pop in the same cycle at one in flight
        cyc(2'b10, 1'b1, 1'b0);
        cyc(2'b01, 1'b1, 1'b1);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1);

        // unexpected response, sticky error, then reset with two in flight
        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        zero_inputs();
        #3;
        chk_all_zero("midreset");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic; stalled sources keep valid and payload
        for (int n = 0; n < 400; n++) begin
            logic [1:0] v;
            logic       r;
            logic       p;
            v = 2'($urandom);
            if (held_m >= 0) v[held_m] = 1'b1;
            r = 1'($urandom_range(3, 0) != 0);
            p = (q_m.size() > 0) ? 1'($urandom) : 1'b0;
            cyc(v, r, p);
        end
        while (q_m.size() > 0) cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
